// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID pipeline register.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (word-align redirect targets, sticky misalign flag).
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic [1:0]  pcsrc_e,
  input  logic [31:0] branch_target_e,
  input  logic [31:0] jalr_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d,
  output logic        misalign
);

  logic [31:0] pc_r;
  logic [31:0] pcplus4_s;
  logic [31:0] target_s;
  logic [31:0] load_target_s;
  logic        redirect_s;

  assign pcplus4_s = pc_r + 32'd4;
  assign imem_addr = pc_r;

  // Redirect target select; pcsrc 11 is reserved and falls through to sequential fetch.
  always_comb begin
    target_s   = pcplus4_s;
    redirect_s = 1'b0;
    case (pcsrc_e)
      2'b01: begin
        target_s   = branch_target_e;
        redirect_s = 1'b1;
      end
      2'b10: begin
        target_s   = jalr_target_e & ~32'd1;
        redirect_s = 1'b1;
      end
      default: begin
        target_s   = pcplus4_s;
        redirect_s = 1'b0;
      end
    endcase
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  logic target_misalign_s;
  logic misalign_r;

  // Misalignment is judged on the raw target so a jalr to an odd address is still flagged.
  always_comb begin
    target_misalign_s = 1'b0;
    case (pcsrc_e)
      2'b01:   target_misalign_s = |branch_target_e[1:0];
      2'b10:   target_misalign_s = |jalr_target_e[1:0];
      default: target_misalign_s = 1'b0;
    endcase
  end

  assign load_target_s = {target_s[31:2], 2'b00};

  // Sticky misalign flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_r <= 1'b0;
    end else if (redirect_s && target_misalign_s) begin
      misalign_r <= 1'b1;
    end else begin
      misalign_r <= misalign_r;
    end
  end

  assign misalign = misalign_r;
`else
  assign load_target_s = target_s;
  assign misalign      = 1'b0;
`endif

  // PC register: a redirect wins over stall_f.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r <= RESET_PC;
    end else if (redirect_s) begin
      pc_r <= load_target_s;
    end else if (stall_f) begin
      pc_r <= pc_r;
    end else begin
      pc_r <= pcplus4_s;
    end
  end

  // IF/ID register: flush beats stall.
  always_ff @(posedge clk) begin
    if (rst || flush_d) begin
      instr_d   <= NOP_INSTR;
      pc_d      <= 32'd0;
      pcplus4_d <= 32'd0;
      valid_d   <= 1'b0;
    end else if (stall_d) begin
      instr_d   <= instr_d;
      pc_d      <= pc_d;
      pcplus4_d <= pcplus4_d;
      valid_d   <= valid_d;
    end else begin
      instr_d   <= imem_rdata;
      pc_d      <= pc_r;
      pcplus4_d <= pcplus4_s;
      valid_d   <= 1'b1;
    end
  end

endmodule
